// File: rtl/sec_locked_pipe.sv
// ============================================================================
// Module   : sec_locked_pipe
// Brief    : Two-stage key-locked SEC-DED decoder with a serial key loader.
//            Optional error counters are enabled by defining SEC_ERR_COUNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sec_locked_pipe #(
    parameter int                DATA_W   = 32,
    parameter int                CHK_W    = 7,
    parameter int                KEY_W    = 26,
    parameter logic [KEY_W-1:0]  KEY_MASK = 26'h15A5A5A,
    parameter int                CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                key_start,
    input  logic                key_valid,
    input  logic                key_bit,
    output logic                key_done,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    input  logic [CHK_W-1:0]    in_chk,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_single,
    output logic                out_double,
    output logic [CHK_W-2:0]    out_syn
`ifdef SEC_ERR_COUNT_EN
    ,
    output logic [CNT_W-1:0]    single_cnt,
    output logic [CNT_W-1:0]    double_cnt
`endif
);

    localparam int SYN_W  = CHK_W - 1;
    localparam int N_POS  = DATA_W + CHK_W - 1;
    localparam int KCNT_W = $clog2(KEY_W + 1);

    typedef enum logic [1:0] {
        S_LOCKED = 2'd0,
        S_SHIFT  = 2'd1,
        S_RUN    = 2'd2
    } state_t;

    // Codeword position of data bit idx: the idx-th non-power-of-two position.
    function automatic int data_pos(input int idx);
        int cnt;
        int pos;
        cnt = 0;
        pos = 0;
        for (int q = 1; q <= N_POS; q++) begin
            if ((q & (q - 1)) != 0) begin
                if (cnt == idx) pos = q;
                cnt++;
            end
        end
        return pos;
    endfunction

    state_t              state_q, state_d;
    logic [KEY_W-1:0]    key_q, key_d;
    logic [KCNT_W-1:0]   kcnt_q, kcnt_d;
    logic                flush;

    logic                v1_q, v2_q;
    logic [SYN_W-1:0]    syn1_q, syn1_d;
    logic                par1_q, par1_d;
    logic [DATA_W-1:0]   data1_q;

    logic [DATA_W-1:0]   odata_q, odata_d;
    logic                osingle_q, osingle_d;
    logic                odouble_q, odouble_d;
    logic [SYN_W-1:0]    osyn_q;

    logic                advance;
    logic                syn_in_range;
    logic [DATA_W-1:0]   mask;

    assign advance  = !v2_q || out_ready;
    assign in_ready = (state_q == S_RUN) && advance;
    assign key_done = (state_q == S_RUN);

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        kcnt_d  = kcnt_q;
        flush   = 1'b0;
        case (state_q)
            S_LOCKED: begin
                if (key_start) begin
                    state_d = S_SHIFT;
                    kcnt_d  = '0;
                end
            end
            S_SHIFT: begin
                if (key_start) begin
                    kcnt_d = '0;
                end else if (key_valid) begin
                    key_d = {key_q[KEY_W-2:0], key_bit};
                    if (kcnt_q == KCNT_W'(KEY_W - 1)) begin
                        kcnt_d  = '0;
                        state_d = S_RUN;
                    end else begin
                        kcnt_d = kcnt_q + KCNT_W'(1);
                    end
                end
            end
            S_RUN: begin
                if (key_start) begin
                    state_d = S_SHIFT;
                    kcnt_d  = '0;
                    flush   = 1'b1;
                end
            end
            default: state_d = S_LOCKED;
        endcase
    end

    // Check bit j lives at position 2^j, so it contributes exactly bit j.
    always_comb begin
        syn1_d = in_chk[SYN_W-1:0];
        par1_d = (^in_chk) ^ (^in_data);
        for (int i = 0; i < DATA_W; i++) begin
            if (in_data[i]) syn1_d = syn1_d ^ SYN_W'(data_pos(i));
        end
    end

    always_comb begin
        syn_in_range = (32'(syn1_q) <= 32'(N_POS));
        odata_d      = data1_q;
        osingle_d    = 1'b0;
        odouble_d    = 1'b0;
        if (syn1_q != '0) begin
            if (par1_q && syn_in_range) begin
                osingle_d = 1'b1;
                for (int i = 0; i < DATA_W; i++) begin
                    if (SYN_W'(data_pos(i)) == syn1_q) odata_d[i] = ~data1_q[i];
                end
            end else begin
                odouble_d = 1'b1;
            end
        end else if (par1_q) begin
            osingle_d = 1'b1;
        end
        for (int i = 0; i < DATA_W; i++) begin
            mask[i] = key_q[i % KEY_W] ^ KEY_MASK[i % KEY_W];
        end
        odata_d = odata_d ^ mask;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_LOCKED;
            key_q     <= '0;
            kcnt_q    <= '0;
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            syn1_q    <= '0;
            par1_q    <= 1'b0;
            data1_q   <= '0;
            odata_q   <= '0;
            osingle_q <= 1'b0;
            odouble_q <= 1'b0;
            osyn_q    <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            kcnt_q  <= kcnt_d;
            if (flush) begin
                v1_q <= 1'b0;
                v2_q <= 1'b0;
            end else if (advance) begin
                v1_q      <= in_valid && in_ready;
                syn1_q    <= syn1_d;
                par1_q    <= par1_d;
                data1_q   <= in_data;
                v2_q      <= v1_q;
                odata_q   <= odata_d;
                osingle_q <= osingle_d;
                odouble_q <= odouble_d;
                osyn_q    <= syn1_q;
            end
        end
    end

    assign out_valid  = v2_q;
    assign out_data   = odata_q;
    assign out_single = osingle_q;
    assign out_double = odouble_q;
    assign out_syn    = osyn_q;

`ifdef SEC_ERR_COUNT_EN
    logic [CNT_W-1:0] scnt_q, dcnt_q;
    logic             out_fire;

    assign out_fire = v2_q && out_ready;

    // Counters survive key reloads; only reset clears them.
    always_ff @(posedge clk) begin
        if (reset) begin
            scnt_q <= '0;
            dcnt_q <= '0;
        end else begin
            if (out_fire && osingle_q && (scnt_q != '1)) scnt_q <= scnt_q + CNT_W'(1);
            if (out_fire && odouble_q && (dcnt_q != '1)) dcnt_q <= dcnt_q + CNT_W'(1);
        end
    end

    assign single_cnt = scnt_q;
    assign double_cnt = dcnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sec_locked_pipe.sv
// ============================================================================
// Module   : tb_sec_locked_pipe
// Brief    : Directed and randomized bench for sec_locked_pipe with a
//            position-array reference decoder and an expected-output queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sec_locked_pipe;

    localparam logic [25:0] C_KEY = 26'h15A5A5A;

    typedef struct packed {
        logic [31:0] d;
        logic        s;
        logic        db;
        logic [5:0]  syn;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        key_start = 1'b0, key_valid = 1'b0, key_bit = 1'b0;
    logic        key_done;
    logic        in_valid = 1'b0, in_ready;
    logic [31:0] in_data = '0;
    logic [6:0]  in_chk = '0;
    logic        out_valid, out_ready = 1'b1;
    logic [31:0] out_data;
    logic        out_single, out_double;
    logic [5:0]  out_syn;

    int          checks = 0;
    int          errors = 0;
    exp_t        q[$];
    exp_t        e;
    logic [25:0] mkey = '0;
    logic        acc;
    logic        hold_prev = 1'b0;
    logic [31:0] held_d;
    logic [31:0] obs_d;
    logic        obs_s, obs_db;
    logic [5:0]  obs_syn;
    logic [38:0] v;

    always #5 clk = ~clk;

    sec_locked_pipe dut (
        .clk(clk), .reset(reset),
        .key_start(key_start), .key_valid(key_valid), .key_bit(key_bit),
        .key_done(key_done),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_chk(in_chk),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_single(out_single),
        .out_double(out_double), .out_syn(out_syn)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Encoder: check bit j equals bit j of the XOR of set data positions.
    function automatic logic [6:0] enc(input logic [31:0] d);
        int syn;
        int di;
        logic [6:0] c;
        syn = 0;
        di  = 0;
        for (int p = 1; p <= 38; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (d[di]) syn = syn ^ p;
                di++;
            end
        end
        c[5:0] = 6'(syn);
        c[6]   = (^d) ^ (^c[5:0]);
        return c;
    endfunction

    function automatic exp_t model(input logic [31:0] d, input logic [6:0] c, input logic [25:0] key);
        logic [38:0] cw;
        int          pos_of[32];
        int          di;
        int          ci;
        int          syn;
        logic        par;
        exp_t        r;
        cw  = '0;
        di  = 0;
        ci  = 0;
        syn = 0;
        for (int p = 1; p <= 38; p++) begin
            if ((p & (p - 1)) == 0) begin
                cw[p] = c[ci];
                ci++;
            end else begin
                cw[p]      = d[di];
                pos_of[di] = p;
                di++;
            end
        end
        par = c[6];
        for (int p = 1; p <= 38; p++) begin
            if (cw[p]) syn = syn ^ p;
            par = par ^ cw[p];
        end
        r.d   = d;
        r.s   = 1'b0;
        r.db  = 1'b0;
        r.syn = 6'(syn);
        if (syn != 0) begin
            if (par && syn <= 38) begin
                r.s = 1'b1;
                for (int i = 0; i < 32; i++) if (pos_of[i] == syn) r.d[i] = ~r.d[i];
            end else begin
                r.db = 1'b1;
            end
        end else if (par) begin
            r.s = 1'b1;
        end
        for (int i = 0; i < 32; i++) r.d[i] = r.d[i] ^ key[i % 26] ^ C_KEY[i % 26];
        return r;
    endfunction

    // One cycle: sample handshakes at the falling edge, then cross the rising edge.
    task automatic step();
        @(negedge clk);
        acc = 1'b0;
        if (hold_prev) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_data", out_data, held_d);
        end
        if (out_valid && !out_ready && !key_start) begin
            check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        hold_prev = out_valid && !out_ready && !key_start;
        held_d    = out_data;
        if (out_valid && out_ready) begin
            obs_d   = out_data;
            obs_s   = out_single;
            obs_db  = out_double;
            obs_syn = out_syn;
            if (q.size() == 0) begin
                check("spurious_out", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                check("sb_data", out_data, e.d);
                check("sb_flags", {30'd0, out_single, out_double}, {30'd0, e.s, e.db});
                check("sb_syn", 32'(out_syn), 32'(e.syn));
            end
        end
        if (in_valid && in_ready) begin
            acc = 1'b1;
            q.push_back(model(in_data, in_chk, mkey));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [25:0] k);
        key_start = 1'b1;
        step();
        key_start = 1'b0;
        for (int i = 25; i >= 0; i--) begin
            key_valid = 1'b1;
            key_bit   = k[i];
            if (i == 0) check("key_done_before_last", 32'(key_done), 32'd0);
            step();
        end
        key_valid = 1'b0;
        check("key_done_after_last", 32'(key_done), 32'd1);
        mkey = k;
    endtask

    // Send one word, then idle until it has been consumed (bounded).
    task automatic send_one(input logic [31:0] d, input logic [6:0] c);
        int guard;
        in_valid = 1'b1;
        in_data  = d;
        in_chk   = c;
        guard    = 0;
        do begin
            step();
            guard++;
        end while (!acc && guard < 20);
        in_valid = 1'b0;
        guard = 0;
        while (q.size() != 0 && guard < 20) begin
            step();
            guard++;
        end
        check("send_done", 32'(q.size()), 32'd0);
    endtask

    initial begin
        int n;
        int guard;

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_key_done", 32'(key_done), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_flags_syn", {24'd0, out_single, out_double, out_syn}, 32'd0);

        load_key(C_KEY);

        // Clean zero word with exact two-cycle latency.
        in_valid = 1'b1; in_data = '0; in_chk = '0; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("lat_accept", 32'(acc), 32'd1);
        check("lat_c1_valid", 32'(out_valid), 32'd0);
        step();
        check("lat_c2_valid", 32'(out_valid), 32'd1);
        check("lat_c2_data", out_data, 32'd0);
        step();

        send_one(32'h00000001, enc(32'h0));
        check("single_data", obs_d, 32'h0);
        check("single_flag", {30'd0, obs_s, obs_db}, 32'd2);
        check("single_syn", 32'(obs_syn), 32'd3);

        send_one(32'h00000003, enc(32'h0));
        check("double_data", obs_d, 32'h3);
        check("double_flag", {30'd0, obs_s, obs_db}, 32'd1);
        check("double_syn", 32'(obs_syn), 32'd6);

        send_one(32'h0, 7'h40);
        check("parity_only_flag", {30'd0, obs_s, obs_db}, 32'd2);

        // Stream of four words with a three-cycle output stall.
        n = 0;
        for (int c = 0; c < 30 && (n < 4 || q.size() != 0); c++) begin
            out_ready = !(c >= 3 && c < 6);
            in_valid  = (n < 4);
            in_data   = $urandom;
            in_chk    = enc(in_data) ^ ((n == 2) ? 7'h04 : 7'h00);
            step();
            if (acc) n++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("stream_sent", 32'(n), 32'd4);
        check("stream_drained", 32'(q.size()), 32'd0);

        // Randomized traffic with 0..2 bit flips and random backpressure.
        for (int c = 0; c < 300; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            in_data   = $urandom;
            v         = {enc(in_data), in_data};
            n         = $urandom_range(0, 2);
            for (int k = 0; k < n; k++) v[$urandom_range(0, 38)] ^= 1'b1;
            {in_chk, in_data} = v;
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        guard = 0;
        while (q.size() != 0 && guard < 20) begin
            step();
            guard++;
        end
        check("random_drained", 32'(q.size()), 32'd0);

        // Wrong key: bits 0 and 26 share key index 0.
        load_key(26'h15A5A5B);
        send_one(32'h0, 7'h0);
        check("wrongkey_data", obs_d, 32'h04000001);
        check("wrongkey_flags", {30'd0, obs_s, obs_db}, 32'd0);

        // Reset in the middle of a key load.
        key_start = 1'b1;
        step();
        key_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            key_valid = 1'b1; key_bit = 1'b1;
            step();
        end
        key_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        hold_prev = 1'b0;
        check("midrst_key_done", 32'(key_done), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_out_data", out_data, 32'd0);

        // key_start while RUN with two words in flight.
        load_key(C_KEY);
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 32'h12345678; in_chk = enc(32'h12345678);
        step();
        in_data = 32'h9ABCDEF0; in_chk = enc(32'h9ABCDEF0);
        step();
        in_valid = 1'b0; out_ready = 1'b0; key_start = 1'b1;
        check("flush_inflight_valid", 32'(out_valid), 32'd1);
        step();
        key_start = 1'b0; out_ready = 1'b1;
        q.delete();
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_key_done", 32'(key_done), 32'd0);
        step();
        check("flush_no_late_out", 32'(out_valid), 32'd0);
        load_key(C_KEY);
        send_one(32'hCAFEF00D, enc(32'hCAFEF00D));
        check("after_flush_data", obs_d, 32'hCAFEF00D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
